// File: rtl/tdm_frame_engine.sv
// TDM frame timing and loopback engine: recovers slot/frame position from c4/f0,
// drives the slot test pattern, a decimated CPU interrupt and the STM delay line.
module tdm_frame_engine #(
  parameter int unsigned SLOTS_PER_FRAME = 64,
  parameter int unsigned PATTERN_HALF    = 2,
  parameter int unsigned FRAMES_PER_INT  = 8,
  parameter int unsigned DELAY_BITS      = 384,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                               clk50,
  input  logic                               reset_n,
  input  logic                               c4,
  input  logic                               f0,
  input  logic                               clk_from_stm,
  input  logic                               data_from_stm,
  input  logic                               int_ack,
  input  logic                               err_clr,
  output logic                               test_120,
  output logic                               data_to_stm,
  output logic                               cpu_int,
  output logic [$clog2(SLOTS_PER_FRAME)-1:0] slot_idx,
  output logic                               locked,
  output logic                               frame_err
);

  localparam int unsigned SLOT_W   = $clog2(SLOTS_PER_FRAME);
  localparam int unsigned FCNT_W   = (FRAMES_PER_INT > 1) ? $clog2(FRAMES_PER_INT) : 1;
  localparam int unsigned START_W  = $clog2(SYNC_STAGES + 2);
  localparam int unsigned PAT_SHIFT = $clog2(PATTERN_HALF);

  localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(SLOTS_PER_FRAME - 1);
  localparam logic [FCNT_W-1:0]  FCNT_LAST  = FCNT_W'(FRAMES_PER_INT - 1);
  localparam logic [START_W-1:0] START_DONE = START_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] c4_sync_q, c4_sync_d;
  logic [SYNC_STAGES-1:0] f0_sync_q, f0_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   c4_hist_q, c4_hist_d;
  logic                   sck_hist_q, sck_hist_d;
  logic [START_W-1:0]     start_cnt_q, start_cnt_d;
  logic [SLOT_W-1:0]      slot_idx_q, slot_idx_d;
  logic                   test_120_q, test_120_d;
  logic                   locked_q, locked_d;
  logic                   seen_q, seen_d;
  logic                   prev_done_q, prev_done_d;
  logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
  logic                   cpu_int_q, cpu_int_d;
  logic                   frame_err_q, frame_err_d;
  logic [DELAY_BITS-1:0]  sr_q, sr_d;
  logic                   data_to_stm_q, data_to_stm_d;

  logic              c4_s, f0_s, sck_s, dat_s;
  logic              edges_en, c4_rise, sck_rise, sck_fall;
  logic              frame_done, int_set, err_set;
  logic [SLOT_W-1:0] pat_quot;

  assign c4_s  = c4_sync_q[SYNC_STAGES-1];
  assign f0_s  = f0_sync_q[SYNC_STAGES-1];
  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  assign edges_en = (start_cnt_q == START_DONE);
  assign c4_rise  = edges_en & c4_s & ~c4_hist_q;
  assign sck_rise = edges_en & sck_s & ~sck_hist_q;
  assign sck_fall = edges_en & ~sck_s & sck_hist_q;

  // Pattern phase is the slot index divided by the (power-of-two) half period.
  assign pat_quot = slot_idx_q >> PAT_SHIFT;

  always_comb begin
    c4_sync_d     = {c4_sync_q[SYNC_STAGES-2:0], c4};
    f0_sync_d     = {f0_sync_q[SYNC_STAGES-2:0], f0};
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], clk_from_stm};
    dat_sync_d    = {dat_sync_q[SYNC_STAGES-2:0], data_from_stm};
    c4_hist_d     = c4_s;
    sck_hist_d    = sck_s;
    start_cnt_d   = edges_en ? start_cnt_q : start_cnt_q + START_W'(1);
    slot_idx_d    = slot_idx_q;
    test_120_d    = test_120_q;
    locked_d      = locked_q;
    seen_d        = seen_q;
    prev_done_d   = prev_done_q;
    fcnt_d        = fcnt_q;
    sr_d          = sr_q;
    data_to_stm_d = data_to_stm_q;
    frame_done    = 1'b0;
    int_set       = 1'b0;
    err_set       = 1'b0;

    if (c4_rise) begin
      if (!f0_s) begin
        slot_idx_d  = '0;
        locked_d    = 1'b1;
        seen_d      = 1'b1;
        prev_done_d = 1'b0;
      end else if (seen_q) begin
        prev_done_d = 1'b0;
        // Missing f0 after a wrap: flag it, restart decimation, keep counting slots.
        if (prev_done_q) begin
          err_set  = 1'b1;
          locked_d = 1'b0;
          fcnt_d   = '0;
        end
        if (slot_idx_q == LAST_SLOT) begin
          frame_done  = 1'b1;
          prev_done_d = 1'b1;
          test_120_d  = 1'b0;
          slot_idx_d  = '0;
          if (locked_q) begin
            if (fcnt_q == FCNT_LAST) begin
              fcnt_d  = '0;
              int_set = 1'b1;
            end else begin
              fcnt_d = fcnt_q + FCNT_W'(1);
            end
          end
        end else begin
          test_120_d = ~pat_quot[0];
          slot_idx_d = slot_idx_q + SLOT_W'(1);
        end
      end
    end

    if (int_set)                   cpu_int_d = 1'b1;
    else if (int_ack | frame_done) cpu_int_d = 1'b0;
    else                           cpu_int_d = cpu_int_q;

    if (err_set)      frame_err_d = 1'b1;
    else if (err_clr) frame_err_d = 1'b0;
    else              frame_err_d = frame_err_q;

    if (sck_fall) sr_d = DELAY_BITS'({sr_q, dat_s});
    if (sck_rise) data_to_stm_d = sr_q[DELAY_BITS-1];
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      c4_sync_q     <= '0;
      f0_sync_q     <= '0;
      sck_sync_q    <= '0;
      dat_sync_q    <= '0;
      c4_hist_q     <= 1'b0;
      sck_hist_q    <= 1'b0;
      start_cnt_q   <= '0;
      slot_idx_q    <= '0;
      test_120_q    <= 1'b0;
      locked_q      <= 1'b0;
      seen_q        <= 1'b0;
      prev_done_q   <= 1'b0;
      fcnt_q        <= '0;
      cpu_int_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      sr_q          <= '0;
      data_to_stm_q <= 1'b0;
    end else begin
      c4_sync_q     <= c4_sync_d;
      f0_sync_q     <= f0_sync_d;
      sck_sync_q    <= sck_sync_d;
      dat_sync_q    <= dat_sync_d;
      c4_hist_q     <= c4_hist_d;
      sck_hist_q    <= sck_hist_d;
      start_cnt_q   <= start_cnt_d;
      slot_idx_q    <= slot_idx_d;
      test_120_q    <= test_120_d;
      locked_q      <= locked_d;
      seen_q        <= seen_d;
      prev_done_q   <= prev_done_d;
      fcnt_q        <= fcnt_d;
      cpu_int_q     <= cpu_int_d;
      frame_err_q   <= frame_err_d;
      sr_q          <= sr_d;
      data_to_stm_q <= data_to_stm_d;
    end
  end

  assign test_120    = test_120_q;
  assign data_to_stm = data_to_stm_q;
  assign cpu_int     = cpu_int_q;
  assign slot_idx    = slot_idx_q;
  assign locked      = locked_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_tdm_frame_engine.sv
// Directed bench for tdm_frame_engine: frame timing, interrupt decimation/ack,
// lost sync, reset mid-frame and an 8-bit loopback delay.
module tb_tdm_frame_engine;

  logic       clk50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       c4 = 1'b0;
  logic       f0 = 1'b1;
  logic       clk_from_stm = 1'b0;
  logic       data_from_stm = 1'b0;
  logic       int_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic       test_120, data_to_stm, cpu_int, locked, frame_err;
  logic [5:0] slot_idx;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic        int_seen = 1'b0;

  always #10 clk50 = ~clk50;

  tdm_frame_engine #(
    .SLOTS_PER_FRAME(64),
    .PATTERN_HALF(2),
    .FRAMES_PER_INT(8),
    .DELAY_BITS(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk50(clk50),
    .reset_n(reset_n),
    .c4(c4),
    .f0(f0),
    .clk_from_stm(clk_from_stm),
    .data_from_stm(data_from_stm),
    .int_ack(int_ack),
    .err_clr(err_clr),
    .test_120(test_120),
    .data_to_stm(data_to_stm),
    .cpu_int(cpu_int),
    .slot_idx(slot_idx),
    .locked(locked),
    .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; c4 = 1'b0; f0 = 1'b1;
    clk_from_stm = 1'b0; data_from_stm = 1'b0; int_ack = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk50);
    reset_n = 1'b1;
    repeat (5) @(negedge clk50);
  endtask

  // One c4 period: f0 set during the low phase, rise, then 4 cycles high.
  task automatic slot(input logic f0v);
    f0 = f0v;
    c4 = 1'b0;
    repeat (4) begin @(negedge clk50); int_seen = int_seen | cpu_int; end
    c4 = 1'b1;
    repeat (4) begin @(negedge clk50); int_seen = int_seen | cpu_int; end
  endtask

  task automatic frame();
    slot(1'b0);
    repeat (64) slot(1'b1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_slot"},  32'(slot_idx),    32'd0);
    check({pfx, "_test"},  32'(test_120),    32'd0);
    check({pfx, "_lock"},  32'(locked),      32'd0);
    check({pfx, "_int"},   32'(cpu_int),     32'd0);
    check({pfx, "_err"},   32'(frame_err),   32'd0);
    check({pfx, "_dat"},   32'(data_to_stm), 32'd0);
  endtask

  initial begin
    #1.5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    do_reset();
    check_all_zero("rst");

    // Nominal frame with pattern 1,1,0,0 and wrap
    slot(1'b0);
    check("nom_lock", 32'(locked), 32'd1);
    check("nom_slot0", 32'(slot_idx), 32'd0);
    check("nom_test0", 32'(test_120), 32'd0);
    for (int j = 1; j < 64; j++) begin
      slot(1'b1);
      check("nom_slot", 32'(slot_idx), 32'(j));
      check("nom_test", 32'(test_120), 32'((((j - 1) / 2) % 2) == 0));
    end
    slot(1'b1);
    check("nom_wrap", 32'(slot_idx), 32'd0);
    check("nom_last_test", 32'(test_120), 32'd0);
    check("nom_lock_end", 32'(locked), 32'd1);
    check("dec_f1", 32'(cpu_int), 32'd0);

    // Decimation: frames 2..17 continue from the nominal frame
    for (int f = 2; f <= 17; f++) begin
      slot(1'b0);
      check("dec_hold", 32'(cpu_int), 32'((f - 1) == 8 || (f - 1) == 16));
      repeat (64) slot(1'b1);
      check("dec_done", 32'(cpu_int), 32'(f == 8 || f == 16));
    end

    // Acknowledge pulse
    do_reset();
    repeat (8) frame();
    check("ack_pre", 32'(cpu_int), 32'd1);
    int_ack = 1'b1;
    @(negedge clk50);
    check("ack_clr", 32'(cpu_int), 32'd0);
    int_ack = 1'b0;

    // Acknowledge held across the setting frame_done
    do_reset();
    repeat (7) frame();
    int_ack = 1'b1;
    int_seen = 1'b0;
    frame();
    check("ack_held_set", 32'(int_seen), 32'd1);
    check("ack_held_clr", 32'(cpu_int), 32'd0);
    int_ack = 1'b0;

    // Missing f0 for one frame
    do_reset();
    repeat (3) frame();
    slot(1'b1);
    check("lost_err", 32'(frame_err), 32'd1);
    check("lost_lock", 32'(locked), 32'd0);
    check("lost_slot", 32'(slot_idx), 32'd1);
    check("lost_test", 32'(test_120), 32'd1);
    repeat (63) slot(1'b1);
    check("lost_wrap", 32'(slot_idx), 32'd0);
    check("lost_lock2", 32'(locked), 32'd0);
    int_seen = 1'b0;
    slot(1'b0);
    check("relock", 32'(locked), 32'd1);
    check("relock_err", 32'(frame_err), 32'd1);
    repeat (64) slot(1'b1);
    repeat (6) frame();
    check("relock_noint", 32'(int_seen), 32'd0);
    frame();
    check("relock_int8", 32'(cpu_int), 32'd1);
    err_clr = 1'b1;
    @(negedge clk50);
    check("err_clr", 32'(frame_err), 32'd0);
    err_clr = 1'b0;

    // Reset mid-frame at slot 30
    do_reset();
    slot(1'b0);
    repeat (30) slot(1'b1);
    check("mid_slot30", 32'(slot_idx), 32'd30);
    reset_n = 1'b0;
    @(negedge clk50);
    check_all_zero("mid_rst");
    repeat (2) @(negedge clk50);
    reset_n = 1'b1;
    repeat (5) @(negedge clk50);
    for (int k = 0; k < 4; k++) begin
      slot(1'b1);
      check("mid_unl_slot", 32'(slot_idx), 32'd0);
      check("mid_unl_lock", 32'(locked), 32'd0);
    end
    slot(1'b0);
    check("mid_relock", 32'(locked), 32'd1);
    check("mid_relock_slot", 32'(slot_idx), 32'd0);
    slot(1'b1);
    check("mid_adv", 32'(slot_idx), 32'd1);

    // Delay line, 8 bits: single 1 on bit 1 reappears after rise of bit 9
    do_reset();
    for (int b = 1; b <= 12; b++) begin
      data_from_stm = (b == 1);
      clk_from_stm = 1'b1;
      repeat (5) @(negedge clk50);
      check("dly_out", 32'(data_to_stm), 32'(b == 9));
      repeat (7) @(negedge clk50);
      clk_from_stm = 1'b0;
      repeat (13) @(negedge clk50);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
